// File: rtl/spi_frame_responder_if.sv
// SPI pins and register-bus signals of the frame responder.
// The responder connects through the slave modport, the SPI master side through the master modport.
interface spi_frame_responder_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  sck_i;
    logic                  sdi_i;
    logic                  cs_ni;
    logic                  sdo_o;
    logic                  sdo_oe;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic                  reg_we;
    logic                  reg_re;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic                  frame_err;

    modport slave (
        input  sck_i, sdi_i, cs_ni, reg_rdata,
        output sdo_o, sdo_oe, reg_addr, reg_wdata,
        output reg_we, reg_re, frame_err
    );

    modport master (
        output sck_i, sdi_i, cs_ni, reg_rdata,
        input  sdo_o, sdo_oe, reg_addr, reg_wdata,
        input  reg_we, reg_re, frame_err
    );
endinterface

// File: rtl/spi_frame_responder.sv
// SPI mode-0 responder turning {R/W, addr, data} frames into register-bus strobes.
// All SPI pins are oversampled in the clk domain; nothing runs on SCK.
module spi_frame_responder #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    spi_frame_responder_if.slave bus
);
    localparam int F  = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(F + 1);
    localparam int RW = (ADDR_WIDTH > DATA_WIDTH - 1) ? ADDR_WIDTH : DATA_WIDTH - 1;
    localparam logic [CW-1:0] C_ADDR = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(F - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(F);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sck_s;
    logic [SYNC_STAGES-1:0] r_sdi_s;
    logic [SYNC_STAGES-1:0] r_cs_s;
    logic [SYNC_STAGES-1:0] r_vld;
    logic                  r_sck_p;
    logic                  r_cs_p;
    logic [CW-1:0]         r_cnt;
    logic                  r_extra;
    logic [RW-1:0]         r_rx;
    logic [DATA_WIDTH-1:0] r_tx;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic                  r_re;
    logic                  r_re_d;
    logic                  r_err;
    logic                  r_sdo;

    logic                  w_sck;
    logic                  w_sdi;
    logic                  w_cs_n;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_cs_fall;
    logic [RW:0]           w_rx_nxt;
    logic                  w_we;
    logic                  w_re;
    logic                  w_err;
    logic                  w_addr_ld;

    assign w_sck     = r_sck_s[SYNC_STAGES-1];
    assign w_sdi     = r_sdi_s[SYNC_STAGES-1];
    assign w_cs_n    = r_cs_s[SYNC_STAGES-1];
    assign w_rise    = w_sck & ~r_sck_p;
    assign w_fall    = ~w_sck & r_sck_p;
    assign w_cs_fall = r_cs_p & ~w_cs_n;
    assign w_rx_nxt  = {r_rx, w_sdi};

    // Pin synchronizers; r_vld marks when the cs chain holds real samples.
    // The cs chain resets low so a frame already in progress at reset is never picked up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_s <= '0;
            r_sdi_s <= '0;
            r_cs_s  <= '0;
            r_vld   <= '0;
            r_sck_p <= 1'b0;
            r_cs_p  <= 1'b0;
        end else begin
            r_sck_s <= {r_sck_s[SYNC_STAGES-2:0], bus.sck_i};
            r_sdi_s <= {r_sdi_s[SYNC_STAGES-2:0], bus.sdi_i};
            r_cs_s  <= {r_cs_s[SYNC_STAGES-2:0], bus.cs_ni};
            r_vld   <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_sck_p <= w_sck;
            r_cs_p  <= w_cs_n;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and strobe decisions; cs_n high always wins over SCK edges.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_err       = 1'b0;
        w_addr_ld   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_cs_fall) w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (w_cs_n) begin
                    w_state_nxt = S_IDLE;
                    w_err       = 1'b1;
                end else if (w_rise && r_cnt == C_ADDR) begin
                    w_addr_ld   = 1'b1;
                    w_re        = w_rx_nxt[ADDR_WIDTH];
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_cs_n) begin
                    w_state_nxt = S_IDLE;
                    w_err       = 1'b1;
                end else if (w_rise && r_cnt == C_LAST) begin
                    w_we        = ~r_rw;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_cs_n) begin
                    w_state_nxt = S_IDLE;
                    w_err       = r_extra;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bit counter and detection of SCK edges beyond a complete frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_extra <= 1'b0;
        end else begin
            if (w_cs_n)                      r_cnt <= '0;
            else if (w_rise && r_cnt != C_MAX) r_cnt <= r_cnt + 1'b1;
            if (r_state == S_IDLE)            r_extra <= 1'b0;
            else if (r_state == S_DONE && w_rise) r_extra <= 1'b1;
        end
    end

    // Receive/transmit shifting, address/data capture and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx    <= '0;
            r_tx    <= '0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_re_d  <= 1'b0;
            r_err   <= 1'b0;
            r_sdo   <= 1'b0;
        end else begin
            r_we   <= w_we;
            r_re   <= w_re;
            r_err  <= w_err;
            r_re_d <= r_re;
            if (w_rise && (r_state == S_ADDR || r_state == S_DATA))
                r_rx <= w_rx_nxt[RW-1:0];
            if (w_addr_ld) begin
                r_addr <= w_rx_nxt[ADDR_WIDTH-1:0];
                r_rw   <= w_rx_nxt[ADDR_WIDTH];
            end
            if (w_we) r_wdata <= w_rx_nxt[DATA_WIDTH-1:0];
            if (r_re_d)
                r_tx <= bus.reg_rdata;
            else if (r_state == S_DATA && w_fall)
                r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            if (r_state != S_DATA) r_sdo <= 1'b0;
            else if (w_fall)       r_sdo <= r_rw & r_tx[DATA_WIDTH-1];
        end
    end

    assign bus.sdo_o     = r_sdo;
    assign bus.sdo_oe    = ~w_cs_n & r_vld[SYNC_STAGES-1];
    assign bus.reg_addr  = r_addr;
    assign bus.reg_wdata = r_wdata;
    assign bus.reg_we    = r_we;
    assign bus.reg_re    = r_re;
    assign bus.frame_err = r_err;
endmodule

// File: tb/tb_spi_frame_responder.sv
// Directed bench for spi_frame_responder: bit-banged SPI master plus a
// register-bus responder that returns read data one cycle after reg_re.
module tb_spi_frame_responder;
    logic clk;
    logic rst_n;

    spi_frame_responder_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus ();

    spi_frame_responder #(
        .ADDR_WIDTH (7),
        .DATA_WIDTH (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk;
    int n_err;

    int   n_we;
    int   n_re;
    int   n_fe;
    int   n_sdo;
    int   n_both;
    logic [6:0] mon_wa;
    logic [7:0] mon_wd;
    logic [6:0] mon_ra;

    logic [7:0]  rd_val;
    logic [31:0] rx;

    int b_we;
    int b_re;
    int b_fe;
    int b_sdo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe and pin monitor, sampled on the inactive edge.
    initial begin
        n_we = 0; n_re = 0; n_fe = 0; n_sdo = 0; n_both = 0;
        mon_wa = '0; mon_wd = '0; mon_ra = '0;
        forever begin
            @(negedge clk);
            if (bus.reg_we === 1'b1) begin
                n_we++;
                mon_wa = bus.reg_addr;
                mon_wd = bus.reg_wdata;
            end
            if (bus.reg_re === 1'b1) begin
                n_re++;
                mon_ra = bus.reg_addr;
            end
            if (bus.frame_err === 1'b1) n_fe++;
            if (bus.sdo_o === 1'b1) n_sdo++;
            if (bus.reg_we === 1'b1 && bus.reg_re === 1'b1) n_both++;
        end
    end

    // Register-bus read responder: data valid only in the cycle after reg_re.
    initial begin
        bus.reg_rdata = 8'hEE;
        forever begin
            @(negedge clk);
            if (bus.reg_re === 1'b1) begin
                @(posedge clk);
                #1 bus.reg_rdata = rd_val;
                @(posedge clk);
                #1 bus.reg_rdata = 8'hEE;
            end
        end
    end

    task automatic snap();
        b_we = n_we; b_re = n_re; b_fe = n_fe; b_sdo = n_sdo;
    endtask

    task automatic spi_bits(input int n, input logic [31:0] v);
        for (int i = n - 1; i >= 0; i--) begin
            bus.sdi_i = v[i];
            repeat (5) @(negedge clk);
            bus.sck_i = 1'b1;
            rx = {rx[30:0], bus.sdo_o};
            repeat (5) @(negedge clk);
            bus.sck_i = 1'b0;
        end
    endtask

    task automatic spi_xfer(input int n, input logic [31:0] v);
        rx = '0;
        @(negedge clk);
        bus.cs_ni = 1'b0;
        spi_bits(n, v);
        bus.sdi_i = 1'b0;
        repeat (5) @(negedge clk);
        bus.cs_ni = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rd_val = 8'h00;
        rx = '0;
        rst_n = 1'b0;
        bus.cs_ni = 1'b1;
        bus.sck_i = 1'b0;
        bus.sdi_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sdo", 32'(bus.sdo_o), 32'h0);
        check("rst_oe", 32'(bus.sdo_oe), 32'h0);
        check("rst_addr", 32'(bus.reg_addr), 32'h0);
        check("rst_wdata", 32'(bus.reg_wdata), 32'h0);
        check("rst_we", 32'(bus.reg_we), 32'h0);
        check("rst_re", 32'(bus.reg_re), 32'h0);
        check("rst_err", 32'(bus.frame_err), 32'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Write 0x15 <- 0xA5
        snap();
        spi_xfer(16, 32'h15A5);
        check("wr_we_cnt", 32'(n_we - b_we), 32'd1);
        check("wr_addr", 32'(mon_wa), 32'h15);
        check("wr_data", 32'(mon_wd), 32'hA5);
        check("wr_re_cnt", 32'(n_re - b_re), 32'd0);
        check("wr_err_cnt", 32'(n_fe - b_fe), 32'd0);
        check("wr_sdo_high", 32'(n_sdo - b_sdo), 32'd0);

        // Read 0x15, bus returns 0x3C
        snap();
        rd_val = 8'h3C;
        spi_xfer(16, 32'h9500);
        check("rd_rx", rx & 32'hFFFF, 32'h003C);
        check("rd_re_cnt", 32'(n_re - b_re), 32'd1);
        check("rd_addr", 32'(mon_ra), 32'h15);
        check("rd_we_cnt", 32'(n_we - b_we), 32'd0);
        check("rd_err_cnt", 32'(n_fe - b_fe), 32'd0);

        // Write aborted after 10 SCK cycles, then a full write
        snap();
        spi_xfer(10, 32'h009);
        check("ab_we_cnt", 32'(n_we - b_we), 32'd0);
        check("ab_err_cnt", 32'(n_fe - b_fe), 32'd1);
        snap();
        spi_xfer(16, 32'h027E);
        check("ab2_we_cnt", 32'(n_we - b_we), 32'd1);
        check("ab2_addr", 32'(mon_wa), 32'h02);
        check("ab2_data", 32'(mon_wd), 32'h7E);
        check("ab2_err_cnt", 32'(n_fe - b_fe), 32'd0);

        // 17 SCK cycles: write happens, frame_err at cs_n rise
        snap();
        spi_xfer(17, 32'h0C1FE);
        check("long_we_cnt", 32'(n_we - b_we), 32'd1);
        check("long_addr", 32'(mon_wa), 32'h60);
        check("long_data", 32'(mon_wd), 32'hFF);
        check("long_err_cnt", 32'(n_fe - b_fe), 32'd1);

        // Reset during the DATA phase of write 0x33 <- 0x55
        snap();
        rx = '0;
        @(negedge clk);
        bus.cs_ni = 1'b0;
        spi_bits(12, 32'h335);
        rst_n = 1'b0;
        #1;
        check("mr_sdo", 32'(bus.sdo_o), 32'h0);
        check("mr_oe", 32'(bus.sdo_oe), 32'h0);
        check("mr_addr", 32'(bus.reg_addr), 32'h0);
        check("mr_wdata", 32'(bus.reg_wdata), 32'h0);
        check("mr_we", 32'(bus.reg_we), 32'h0);
        check("mr_re", 32'(bus.reg_re), 32'h0);
        check("mr_err", 32'(bus.frame_err), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        spi_bits(4, 32'h5);
        repeat (5) @(negedge clk);
        bus.cs_ni = 1'b1;
        repeat (10) @(negedge clk);
        check("mr_we_cnt", 32'(n_we - b_we), 32'd0);
        check("mr_err_cnt", 32'(n_fe - b_fe), 32'd0);
        snap();
        rd_val = 8'h00;
        spi_xfer(16, 32'h8000);
        check("mr_rd_rx", rx & 32'hFFFF, 32'h0000);
        check("mr_rd_re_cnt", 32'(n_re - b_re), 32'd1);
        check("mr_rd_addr", 32'(mon_ra), 32'h00);

        // Back-to-back write then read with echoed data
        snap();
        spi_xfer(16, 32'h1011);
        rd_val = mon_wd;
        spi_xfer(16, 32'h9000);
        check("bb_we_cnt", 32'(n_we - b_we), 32'd1);
        check("bb_wdata", 32'(mon_wd), 32'h11);
        check("bb_re_cnt", 32'(n_re - b_re), 32'd1);
        check("bb_rd_addr", 32'(mon_ra), 32'h10);
        check("bb_rx", rx & 32'hFF, 32'h11);
        check("bb_err_cnt", 32'(n_fe - b_fe), 32'd0);

        check("we_re_overlap", 32'(n_both), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
